// File: rtl/ext_int_ctrl.sv
// Machine-external interrupt controller: latches rising edges on peripheral lines,
// picks the lowest-index enabled pending source and runs the req/take/mret handshake.
module ext_int_ctrl #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_en,
  input  logic            int_taken,
  input  logic            ret,
  output logic            int_req,
  output logic [IDW-1:0]  active_id,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  winner;
  logic            any_elig;
  logic            take_now;

  assign rise     = irq_src & ~src_q;
  assign elig     = pending & irq_en;
  assign any_elig = |elig;
  assign take_now = (state == REQ) && int_taken;

  // Descending scan so the lowest eligible index is the last assignment to stick.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      clr[i] = take_now && (active_id == IDW'(i));
    end
  end

  // A new edge in the same cycle as the take keeps the bit set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_id <= '0;
    end else if ((state == IDLE) && any_elig) begin
      active_id <= winner;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_elig)  state_nxt = REQ;
      REQ:     if (int_taken) state_nxt = SERVICE;
      SERVICE: if (ret)       state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decode the state register only, so nothing combinational reaches them.
  always_comb begin
    int_req = (state == REQ);
    busy    = (state == SERVICE);
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Randomised and directed bench for ext_int_ctrl, checked each cycle against a
// behavioural model of the request/service handshake.
module tb_ext_int_ctrl;

  logic       clock;
  logic       reset_n;
  logic [7:0] irq_src;
  logic [7:0] irq_en;
  logic       int_taken;
  logic       ret;
  logic       int_req;
  logic [2:0] active_id;
  logic [7:0] pending;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] m_pend;
  logic [7:0] m_prev;
  bit         m_req;
  bit         m_svc;
  int         m_id;

  ext_int_ctrl #(.NSRC(8), .IDW(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .irq_src   (irq_src),
    .irq_en    (irq_en),
    .int_taken (int_taken),
    .ret       (ret),
    .int_req   (int_req),
    .active_id (active_id),
    .pending   (pending),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic modelReset();
    m_pend = '0;
    m_prev = '0;
    m_req  = 0;
    m_svc  = 0;
    m_id   = 0;
  endtask

  // One clock of the handshake, evaluated from the inputs seen at the edge.
  task automatic modelStep();
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] elig;
    rise   = irq_src & ~m_prev;
    m_prev = irq_src;
    clr    = '0;
    elig   = m_pend & irq_en;
    if (!m_req && !m_svc) begin
      if (elig != 0) begin
        m_id  = lowest(elig);
        m_req = 1;
      end
    end else if (m_req) begin
      if (int_taken) begin
        clr[m_id] = 1'b1;
        m_req     = 0;
        m_svc     = 1;
      end
    end else if (ret) begin
      m_svc = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
  endtask

  task automatic applyStimulus(input logic [7:0] src, input logic [7:0] en,
                               input logic taken, input logic rt);
    irq_src   = src;
    irq_en    = en;
    int_taken = taken;
    ret       = rt;
    @(posedge clock);
    modelStep();
    #1;
    checkOutput("model_int_req", 32'(int_req), 32'(m_req));
    checkOutput("model_busy", 32'(busy), 32'(m_svc));
    checkOutput("model_pending", 32'(pending), 32'(m_pend));
    checkOutput("model_active_id", 32'(active_id), 32'(m_id));
  endtask

  initial begin
    logic [7:0] rsrc;
    logic [7:0] ren;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    irq_src   = '0;
    irq_en    = 8'hFF;
    int_taken = 1'b0;
    ret       = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("reset_int_req", 32'(int_req), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_active_id", 32'(active_id), 32'd0);

    // Single source, full handshake
    applyStimulus(8'h20, 8'hFF, 0, 0);
    checkOutput("t1_pending", 32'(pending), 32'h20);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    checkOutput("t1_req", 32'(int_req), 32'd1);
    checkOutput("t1_id", 32'(active_id), 32'd5);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    checkOutput("t1_req_drop", 32'(int_req), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_pending_clr", 32'(pending), 32'h00);
    applyStimulus(8'h00, 8'hFF, 0, 1);

    // Simultaneous edges: lower index first, the other after mret
    applyStimulus(8'h44, 8'hFF, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    checkOutput("t2_first_id", 32'(active_id), 32'd2);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);
    checkOutput("t2_idle_req", 32'(int_req), 32'd0);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    checkOutput("t2_second_req", 32'(int_req), 32'd1);
    checkOutput("t2_second_id", 32'(active_id), 32'd6);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);

    // Higher priority arrival and mask clear do not retarget a held request
    applyStimulus(8'h10, 8'hFF, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    applyStimulus(8'h02, 8'hFF, 0, 0);
    checkOutput("t3_frozen_id", 32'(active_id), 32'd4);
    applyStimulus(8'h00, 8'h00, 0, 0);
    checkOutput("t3_masked_hold", 32'(int_req), 32'd1);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    checkOutput("t3_next_id", 32'(active_id), 32'd1);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);

    // Disabled source stays pending until enabled
    applyStimulus(8'h08, 8'h00, 0, 0);
    checkOutput("t4_pending", 32'(pending), 32'h08);
    applyStimulus(8'h00, 8'h00, 0, 0);
    checkOutput("t4_no_req", 32'(int_req), 32'd0);
    applyStimulus(8'h00, 8'h08, 0, 0);
    checkOutput("t4_req", 32'(int_req), 32'd1);
    checkOutput("t4_id", 32'(active_id), 32'd3);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);

    // Stray handshake pulses and set-beats-clear
    applyStimulus(8'h00, 8'hFF, 1, 0);
    checkOutput("t5_taken_idle_busy", 32'(busy), 32'd0);
    applyStimulus(8'h01, 8'hFF, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);
    checkOutput("t5_ret_in_req", 32'(int_req), 32'd1);
    applyStimulus(8'h01, 8'hFF, 1, 0);
    checkOutput("t5_set_wins", 32'(pending), 32'h01);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    applyStimulus(8'h00, 8'hFF, 0, 1);
    applyStimulus(8'h00, 8'hFF, 0, 0);
    checkOutput("t5_rearb_id", 32'(active_id), 32'd0);
    applyStimulus(8'h00, 8'hFF, 1, 0);
    applyStimulus(8'h00, 8'hFF, 0, 1);

    // Asynchronous reset in the middle of service
    applyStimulus(8'h80, 8'hFF, 0, 0);
    applyStimulus(8'h80, 8'hFF, 0, 0);
    applyStimulus(8'hC0, 8'hFF, 1, 0);
    checkOutput("t6_busy_before", 32'(busy), 32'd1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rst_int_req", 32'(int_req), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_pending", 32'(pending), 32'd0);
    checkOutput("t6_rst_active_id", 32'(active_id), 32'd0);
    irq_src = 8'h80;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(8'h80, 8'hFF, 0, 0);
    checkOutput("t6_new_edge", 32'(pending), 32'h80);
    applyStimulus(8'h80, 8'hFF, 0, 0);
    checkOutput("t6_req_id", 32'(active_id), 32'd7);

    // Random traffic against the model
    rsrc = 8'h80;
    ren  = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      rsrc = rsrc ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 19) == 0) ren = 8'($urandom);
      applyStimulus(rsrc, ren, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
